// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU-drive and result signals of alu_issue_ctrl, grouped for port binding.
// Signal suffixes are from the controller's point of view (master = controller).
interface alu_issue_ctrl_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [2:0] cmd_op_i;
    logic [7:0] cmd_a_i;
    logic [7:0] cmd_b_i;
    logic       cmd_acc_i;
    logic [7:0] alu_a_o;
    logic [7:0] alu_b_o;
    logic [2:0] alu_op_o;
    logic [7:0] alu_res_i;
    logic       res_valid_o;
    logic       res_ready_i;
    logic [7:0] res_data_o;
    logic [2:0] res_op_o;
    logic [7:0] acc_o;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_acc_i, alu_res_i, res_ready_i,
        output cmd_ready_o, alu_a_o, alu_b_o, alu_op_o, res_valid_o, res_data_o, res_op_o, acc_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i, cmd_acc_i, alu_res_i, res_ready_i,
        input  cmd_ready_o, alu_a_o, alu_b_o, alu_op_o, res_valid_o, res_data_o, res_op_o, acc_o
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues commands to a combinational 8-bit ALU, captures each result one cycle later
// into a small FIFO and keeps the last result as an accumulator for chaining.
module alu_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_issue_ctrl_if.master  bus,
    output logic              dbg_state_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends combinationally on valid or on the other channel's ready.
    state_t         state_q, state_d;
    logic [7:0]     alu_a_q, alu_a_d;
    logic [7:0]     alu_b_q, alu_b_d;
    logic [2:0]     alu_op_q, alu_op_d;
    logic [7:0]     acc_q, acc_d;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [10:0]    mem_q [DEPTH];

    logic cmd_ready;
    logic push;
    logic pop;
    logic res_valid;

    assign res_valid = (count_q != '0);
    assign pop       = res_valid && bus.res_ready_i;

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        acc_d     = acc_q;
        cmd_ready = 1'b0;
        push      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = (count_q < DEPTH_C);
                if (bus.cmd_valid_i && cmd_ready) begin
                    alu_a_d  = bus.cmd_acc_i ? acc_q : bus.cmd_a_i;
                    alu_b_d  = bus.cmd_b_i;
                    alu_op_d = bus.cmd_op_i;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // Free slot was guaranteed at acceptance, so this push never overflows.
                push    = 1'b1;
                acc_d   = bus.alu_res_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.alu_op_o, bus.alu_res_i};
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.alu_a_o     = alu_a_q;
    assign bus.alu_b_o     = alu_b_q;
    assign bus.alu_op_o    = alu_op_q;
    assign bus.acc_o       = acc_q;
    assign bus.res_valid_o = res_valid;
    assign bus.res_data_o  = mem_q[rd_ptr_q][7:0];
    assign bus.res_op_o    = mem_q[rd_ptr_q][10:8];
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomised scoreboard bench for alu_issue_ctrl with a behavioural ALU and result model.
module tb_alu_issue_ctrl;
    logic clk;
    logic reset_n;
    logic dbg_state;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [10:0] exp_q[$];
    logic [7:0]  model_acc = 8'h00;
    bit          rand_ready = 0;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a << b;
            3'd3:    return a >> b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return (a == b) ? 8'h01 : 8'h00;
        endcase
    endfunction

    assign bus.alu_res_i = alu_fn(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop handshake is compared against the head of the expected queue.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && bus.res_valid_o && bus.res_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got 0x%0h expected none at %0t", bus.res_data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", bus.res_data_o, e[7:0]);
                    check("res_op", bus.res_op_o, e[10:8]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.res_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Offers one command (caller is just after a rising edge) and follows it through EXEC.
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic acc, input bit pop_exec);
        logic [7:0] a_eff;
        logic [7:0] r;
        int waited;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_a_i     = a;
        bus.cmd_b_i     = b;
        bus.cmd_acc_i   = acc;
        waited = 0;
        @(negedge clk);
        while (!bus.cmd_ready_o && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.cmd_ready_o) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.cmd_valid_i = 1'b0;
            return;
        end
        a_eff = acc ? model_acc : a;
        r     = alu_fn(op, a_eff, b);
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        exp_q.push_back({op, r});
        model_acc = r;
        if (pop_exec) bus.res_ready_i = 1'b1;
        check("alu_a", bus.alu_a_o, a_eff);
        check("alu_b", bus.alu_b_o, b);
        check("alu_op", bus.alu_op_o, op);
        @(negedge clk);
        check("exec_ready_low", bus.cmd_ready_o, 1'b0);
        @(posedge clk);
        #1;
        if (pop_exec) bus.res_ready_i = 1'b0;
        check("acc", bus.acc_o, r);
        check("res_valid_after_push", bus.res_valid_o, 1'b1);
    endtask

    task automatic drain();
        int waited;
        rand_ready = 0;
        bus.res_ready_i = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            waited++;
            @(posedge clk);
            #1;
        end
        check("drain_remaining", exp_q.size(), 0);
        bus.res_ready_i = 1'b0;
        @(negedge clk);
        check("drain_empty", bus.res_valid_o, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready_o, 1'b1);
        check({tag, "_res_valid"}, bus.res_valid_o, 1'b0);
        check({tag, "_acc"}, bus.acc_o, 8'h00);
        check({tag, "_alu_a"}, bus.alu_a_o, 8'h00);
        check({tag, "_alu_b"}, bus.alu_b_o, 8'h00);
        check({tag, "_alu_op"}, bus.alu_op_o, 3'b000);
        check({tag, "_state"}, dbg_state, 1'b0);
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 3'd0;
        bus.cmd_a_i     = 8'h00;
        bus.cmd_b_i     = 8'h00;
        bus.cmd_acc_i   = 1'b0;
        bus.res_ready_i = 1'b0;
        reset_n = 1'b0;

        // Reset values, during and after reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_in");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("rst_out");

        // ADD with wrap
        send_cmd(3'd0, 8'hF0, 8'h20, 1'b0, 1'b0);
        check("t2_acc", bus.acc_o, 8'h10);
        check("t2_head_data", bus.res_data_o, 8'h10);
        check("t2_head_op", bus.res_op_o, 3'd0);
        drain();

        // Accumulator chain
        send_cmd(3'd1, 8'h00, 8'h11, 1'b1, 1'b0);
        check("t3_sub", bus.acc_o, 8'hFF);
        send_cmd(3'd3, 8'h00, 8'h04, 1'b1, 1'b0);
        check("t3_lsr", bus.acc_o, 8'h0F);
        send_cmd(3'd7, 8'h5A, 8'h5A, 1'b0, 1'b0);
        check("t3_eql", bus.acc_o, 8'h01);
        drain();

        // Backpressure: fifth command must wait for a pop
        for (int i = 1; i <= 4; i++) send_cmd(3'd0, 8'(i), 8'h00, 1'b0, 1'b0);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = 3'd0;
        bus.cmd_a_i     = 8'h05;
        bus.cmd_b_i     = 8'h00;
        bus.cmd_acc_i   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("full_ready_low", bus.cmd_ready_o, 1'b0);
            check("full_alu_a_held", bus.alu_a_o, 8'h04);
        end
        @(posedge clk);
        #1;
        bus.res_ready_i = 1'b1;
        send_cmd(3'd0, 8'h05, 8'h00, 1'b0, 1'b0);
        drain();

        // Simultaneous push/pop at count=2, across pointer wrap
        send_cmd(3'(($urandom_range(0, 7))), 8'($urandom), 8'($urandom_range(0, 9)), 1'b0, 1'b0);
        send_cmd(3'(($urandom_range(0, 7))), 8'($urandom), 8'($urandom_range(0, 9)), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            send_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom_range(0, 9)),
                     1'($urandom_range(0, 1)), 1'b1);
        end
        check("pp_still_valid", bus.res_valid_o, 1'b1);
        check("pp_pending", exp_q.size(), 2);
        drain();

        // Reset in the middle of EXEC
        send_cmd(3'd6, 8'h3C, 8'h0F, 1'b0, 1'b0);
        drain();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = 3'd0;
        bus.cmd_a_i     = 8'h01;
        bus.cmd_b_i     = 8'h01;
        bus.cmd_acc_i   = 1'b0;
        @(negedge clk);
        check("t6_accept_ready", bus.cmd_ready_o, 1'b1);
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        check("t6_in_exec", dbg_state, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        model_acc = 8'h00;
        check_reset_vals("t6_rst");
        @(negedge clk);
        reset_n = 1'b1;
        bus.res_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_result", bus.res_valid_o, 1'b0);
        check("t6_acc", bus.acc_o, 8'h00);
        check("t6_ready", bus.cmd_ready_o, 1'b1);
        bus.res_ready_i = 1'b0;

        // Random traffic with random consumer backpressure
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            send_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom_range(0, 9)),
                     1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

- Command initiator for the 8-bit combinational ALU (ops: ADD, SUB, SLL, LSR, AND, OR, XOR, EQL; 3-bit `encode_op`).
- Accepts operation commands over a valid/ready interface and drives registered operands and opcode to the ALU.
- Samples the ALU result one cycle later into a result FIFO, which is drained over a second valid/ready interface.
- Keeps an 8-bit accumulator so commands can chain on the previous result.

## Interface

Parameters:
- `DEPTH`, 4: result FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  block can accept a command this cycle.
- `cmd_op_i`  in  3  ALU opcode; same encoding as the ALU.
- `cmd_a_i`  in  8  operand a; ignored when `cmd_acc_i`=1.
- `cmd_b_i`  in  8  operand b.
- `cmd_acc_i`  in  1  use the accumulator as operand a.
- `alu_a_o`  out  8  registered operand a to the ALU.
- `alu_b_o`  out  8  registered operand b to the ALU.
- `alu_op_o`  out  3  registered opcode to the ALU.
- `alu_res_i`  in  8  combinational ALU result.
- `res_valid_o`  out  1  FIFO non-empty.
- `res_ready_i`  in  1  consumer takes the head entry.
- `res_data_o`  out  8  head result.
- `res_op_o`  out  3  opcode that produced the head result.
- `acc_o`  out  8  current accumulator value.

## Operation

States: IDLE, EXEC.

IDLE:
- `cmd_ready_o` = (count < DEPTH), combinational from the registered count.
- On `cmd_valid_i && cmd_ready_o`:
  - `alu_a_o` ← (`cmd_acc_i` ? acc : `cmd_a_i`).
  - `alu_b_o` ← `cmd_b_i`.
  - `alu_op_o` ← `cmd_op_i`.
  - Go to EXEC.
- Otherwise hold all ALU drive registers.

EXEC (always exactly one cycle):
- `cmd_ready_o` = 0.
- At the edge: push {`alu_op_o`, `alu_res_i`} into the FIFO tail, set acc ← `alu_res_i`, go to IDLE.
- The push cannot overflow: acceptance required count < DEPTH, and count only grows via this push.

ALU drive registers:
- Keep their last values after EXEC; they are not cleared.

Result FIFO:
- `res_valid_o` = (count ≠ 0). `res_data_o` / `res_op_o` = head entry.
- Pop on `res_valid_o && res_ready_i`.
- Strict FIFO order.
- Read and write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pop when empty: impossible, because valid is low.

Accumulator:
- Updated only in EXEC.
- Every result updates it, including EQL (0x01 or 0x00).

Arithmetic:
- The block performs none.
- Carry/borrow is dropped by the ALU; the 8-bit wrap is passed through unchanged.

Reset (asserted, asynchronous, any state including mid-EXEC):
- State → IDLE.
- count = 0 and pointers = 0.
- acc = 0.
- `alu_a_o` = `alu_b_o` = 0 and `alu_op_o` = 3'b000.
- Any in-flight command is discarded and is never pushed.
- Outputs during reset: `cmd_ready_o`=1, `res_valid_o`=0, `acc_o`=0x00. `res_data_o` and `res_op_o` are don't-care while `res_valid_o`=0.

## Timing

- Command handshake at edge N: ALU drive registers update at edge N; EXEC occupies cycle N→N+1.
- Result pushed at edge N+1. If the FIFO was empty, `res_valid_o`=1 from N+1.
- Latency is 1 cycle from acceptance to result visibility.
- Throughput: one command per 2 cycles maximum; `cmd_ready_o` toggles 1,0,1,0 under continuous valid.
- Back-to-back chaining with `cmd_acc_i`=1 always sees the previous result, because acc updates at the EXEC edge before the next IDLE acceptance.
- Full FIFO: `cmd_ready_o` stays 0 in IDLE until a pop lowers count. It rises in the cycle after the pop edge.
- `res_ready_i` has no combinational path to `cmd_ready_o`.

## Test plan

1. Reset:
   - Stimulus: assert `reset_n`=0.
   - Required: `cmd_ready_o`=1, `res_valid_o`=0, `acc_o`=0x00, `alu_a_o`=`alu_b_o`=0x00, `alu_op_o`=3'b000.
   - Stimulus: release reset.
   - Required: the same values hold.
2. ADD wrap:
   - Stimulus: op=000, a=0xF0, b=0x20.
   - Required: `alu_a_o`=0xF0 one edge after acceptance; `res_valid_o`=1 with `res_data_o`=0x10 and `res_op_o`=000 one edge later; `acc_o`=0x10.
3. Accumulator chain:
   - Stimulus: after test 2, op=001 with `cmd_acc_i`=1, b=0x11.
   - Required: result 0xFF.
   - Stimulus: op=011 with `cmd_acc_i`=1, b=0x04.
   - Required: result 0x0F.
   - Stimulus: op=111, a=0x5A, b=0x5A.
   - Required: result 0x01.
   - All three results are dequeued in order.
4. Backpressure (DEPTH=4):
   - Stimulus: hold `res_ready_i`=0 and offer 5 ADD commands with a=1..5, b=0.
   - Required: exactly 4 accepted; `cmd_ready_o` stays 0 with the FIFO full.
   - Stimulus: raise `res_ready_i`.
   - Required: outputs 1,2,3,4, then the 5th command is accepted and yields 5.
5. Simultaneous push/pop:
   - Stimulus: count=2, `res_ready_i`=1 during the EXEC edge.
   - Required: count remains 2; head advances; order is intact across pointer wrap over ≥ 10 commands.
6. Reset mid-EXEC:
   - Stimulus: assert `reset_n`=0 during EXEC of op=000, a=0x01, b=0x01.
   - Required: no result appears after release; count=0; acc=0x00; `cmd_ready_o`=1.
